// File: rtl/seq_multiply_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_multiply_if : operand/result bundle for the sequential multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
interface seq_multiply_if;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] prod_lo;
  logic [31:0] prod_hi;

  modport master (
    output inp1, inp2, start,
    input  busy, done, prod_lo, prod_hi
  );

  modport slave (
    input  inp1, inp2, start,
    output busy, done, prod_lo, prod_hi
  );
endinterface
`default_nettype wire

// File: rtl/seq_multiply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_multiply : 32x32 unsigned shift-add multiplier, one multiplier bit/cycle.
// Optional early exit compiled in with SEQ_MULTIPLY_EARLY_EXIT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module seq_multiply (
  input  wire logic     clk,
  input  wire logic     rst_n,
  seq_multiply_if.slave mul_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  // Accumulator bit 0 is always zero while running, so it is not stored.
  logic [63:1] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;

  logic [32:0] sum;
  logic [63:0] step_acc;
  logic        last_step;
  logic [63:0] final_acc;

  always_comb begin
    sum      = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    step_acc = {sum, acc_q[31:1]};
  end

`ifdef SEQ_MULTIPLY_EARLY_EXIT_EN
  logic [4:0] shift_amt;

  // Once no multiplier bits remain, the outstanding iterations are pure shifts.
  always_comb begin
    last_step = (mplier_q[31:1] == 31'd0);
    shift_amt = 5'd31 - cnt_q;
    final_acc = step_acc >> shift_amt;
  end
`else
  always_comb begin
    last_step = (cnt_q == 5'd31);
    final_acc = step_acc;
  end
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_if.start) begin
          state_d  = ST_RUN;
          mcand_d  = mul_if.inp1;
          mplier_d = mul_if.inp2;
          acc_d    = '0;
          cnt_d    = 5'd0;
        end
      end
      ST_RUN: begin
        acc_d    = step_acc[63:1];
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (last_step) begin
          state_d = ST_DONE;
          prod_d  = final_acc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign mul_if.busy    = (state_q == ST_RUN);
  assign mul_if.done    = (state_q == ST_DONE);
  assign mul_if.prod_lo = prod_q[31:0];
  assign mul_if.prod_hi = prod_q[63:32];

endmodule
`default_nettype wire

// File: tb/tb_seq_multiply.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_multiply : directed bench for seq_multiply with a cycle-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seq_multiply;

`ifdef SEQ_MULTIPLY_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seq_multiply_if mul_if ();

  seq_multiply dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_if (mul_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles spent busy for a given multiplier value.
  function automatic int unsigned run_len(input logic [31:0] b);
    int unsigned n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`ifndef SEQ_MULTIPLY_EARLY_EXIT_EN
    n = 32;
`endif
    return n;
  endfunction

  // Model: cycles left busy, a done flag, and the last delivered product.
  int unsigned m_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
      m_pend = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end else if (mul_if.start) begin
      m_pend = {32'd0, mul_if.inp1} * {32'd0, mul_if.inp2};
      m_left = run_len(mul_if.inp2);
    end
  end

  always @(negedge clk) begin
    check("model_busy", 64'(mul_if.busy), 64'(m_left != 0));
    check("model_done", 64'(mul_if.done), 64'(m_done));
    check("model_prod", {mul_if.prod_hi, mul_if.prod_lo}, m_prod);
  end

  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat);
    int lat;
    @(negedge clk);
    mul_if.inp1  = a;
    mul_if.inp2  = b;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    lat = 1;
    while (!mul_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_prod"}, {mul_if.prod_hi, mul_if.prod_lo}, exp_p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int dcount;
    int pulse_at;
    logic [63:0] seen;

    mul_if.inp1  = '0;
    mul_if.inp2  = '0;
    mul_if.start = 1'b0;

    // Reset held three cycles
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(mul_if.busy), 64'd0);
    check("rst_done", 64'(mul_if.done), 64'd0);
    check("rst_hi", 64'(mul_if.prod_hi), 64'd0);
    check("rst_lo", 64'(mul_if.prod_lo), 64'd0);

    do_mul("basic", 32'd7, 32'd6, 64'd42, EE ? 4 : 33);
    do_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    do_mul("hi_bit", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, EE ? 3 : 33);
    do_mul("mixed", 32'h1234_5678, 32'h9ABC_DEF0,
           {32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF0}, 33);
    do_mul("zero_a", 32'd0, 32'h0000_FFFF, 64'd0, EE ? 17 : 33);

    // Start pulse and input change during RUN are ignored
    pulse_at = EE ? 2 : 10;
    @(negedge clk);
    mul_if.inp1  = 32'd3;
    mul_if.inp2  = 32'd5;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    lat    = 1;
    dcount = 0;
    seen   = '0;
    while (lat < 80) begin
      if (mul_if.done) begin
        dcount++;
        seen = {mul_if.prod_hi, mul_if.prod_lo};
      end
      if (lat == pulse_at) begin
        mul_if.inp1  = 32'd9;
        mul_if.inp2  = 32'd9;
        mul_if.start = 1'b1;
      end else begin
        mul_if.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("ign_done_count", 64'(dcount), 64'd1);
    check("ign_prod", seen, 64'd15);

    // Start held high: back-to-back operations
    @(negedge clk);
    mul_if.inp1  = 32'd3;
    mul_if.inp2  = 32'h8000_0001;
    mul_if.start = 1'b1;
    dcount = 0;
    for (int i = 1; i <= 68; i++) begin
      @(negedge clk);
      if (mul_if.done) dcount++;
      if (i == 35) check("hold_busy35", 64'(mul_if.busy), 64'd1);
    end
    mul_if.start = 1'b0;
    check("hold_done_count", 64'(dcount), 64'd2);
    check("hold_prod", {mul_if.prod_hi, mul_if.prod_lo}, 64'h0000_0001_8000_0003);

    // Reset in the middle of RUN
    @(negedge clk);
    mul_if.inp1  = 32'hDEAD_BEEF;
    mul_if.inp2  = 32'h8000_0000;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_busy_before", 64'(mul_if.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(mul_if.busy), 64'd0);
    check("mid_rst_done", 64'(mul_if.done), 64'd0);
    check("mid_rst_prod", {mul_if.prod_hi, mul_if.prod_lo}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_if.done) dcount++;
    end
    check("mid_no_done", 64'(dcount), 64'd0);
    do_mul("after_rst", 32'd2, 32'd2, 64'd4, EE ? 3 : 33);

    // Short multipliers (early exit when enabled)
    do_mul("one", 32'd100, 32'd1, 64'd100, EE ? 2 : 33);
    do_mul("zero_b", 32'd5, 32'd0, 64'd0, EE ? 2 : 33);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_multiply.md
SEQ_MULTIPLY -- requirements
Module: seq_multiply

Interface
REQ-001 The block SHALL have one clock and one reset: clk (input, 1, rising-edge clock); rst_n (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL have port inp1 (input, 32): multiplicand, unsigned.
REQ-003 The block SHALL have port inp2 (input, 32): multiplier, unsigned.
REQ-004 The block SHALL have port start (input, 1): request a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port busy (output, 1): high while in RUN.
REQ-006 The block SHALL have port done (output, 1): single-cycle pulse, result valid.
REQ-007 The block SHALL have port prod_lo (output, 32): product bits [31:0].
REQ-008 The block SHALL have port prod_hi (output, 32): product bits [63:32].

Function
REQ-009 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-010 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after the final iteration; DONE->IDLE unconditionally after one cycle.
REQ-011 On the start edge in IDLE, inp1 and inp2 SHALL be latched into internal registers; input changes after that edge SHALL NOT affect the result.
REQ-012 Each RUN cycle SHALL perform one shift-add step (see the list below).
- If the multiplier register LSB is 1, add the 32-bit multiplicand to the upper 32 bits of a 64-bit accumulator, keeping the 33-bit carry.
- Shift {carry, accumulator} right by 1.
- Shift the multiplier register right by 1.
REQ-013 Without early exit, RUN SHALL last exactly 32 cycles. done SHALL assert 33 cycles after the start edge; busy SHALL be high for exactly cycles 1..32.
REQ-014 done SHALL be high for exactly one cycle, in DONE; busy SHALL be 0 in IDLE and DONE.
REQ-015 prod_hi and prod_lo SHALL update only on entry to DONE.
- They SHALL hold their value until the next DONE entry or reset.
- They SHALL NOT show partial products.
REQ-016 The product SHALL be the exact 64-bit unsigned product; no overflow or truncation SHALL occur.
REQ-017 start while in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-018 start held high continuously SHALL begin a new operation on the cycle after DONE, once back in IDLE.
REQ-019 Zero operands SHALL give product 0 with the normal latency, unless REQ-024 applies.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously force: state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, and all internal registers to 0.
REQ-021 Reset asserted during RUN SHALL abort the operation; no done SHALL follow after release.
REQ-022 After rst_n deasserts, the first rising clk edge with start=1 SHALL be accepted normally.

Configuration
REQ-023 The block SHALL provide macro SEQ_MULTIPLY_EARLY_EXIT_EN to compile the early-exit feature in or out.
REQ-024 With SEQ_MULTIPLY_EARLY_EXIT_EN defined, early exit SHALL be enabled (see the list below).
- When the remaining multiplier register is 0 at the start of a RUN cycle, the FSM SHALL go to DONE.
- Before going to DONE, the accumulator SHALL be shifted right by the count of remaining iterations in that single cycle.
- RUN length SHALL be max(1, index of the highest set bit of inp2 + 1) cycles.
- The product SHALL be identical to the fixed-latency result.
REQ-025 Without SEQ_MULTIPLY_EARLY_EXIT_EN, RUN SHALL always take 32 cycles, and no early-exit logic SHALL be synthesized.

Verification
REQ-026 The bench SHALL cover reset: hold rst_n=0 3 cycles, then release -> busy=0, done=0, prod_hi=0, prod_lo=0.
REQ-027 The bench SHALL cover a basic multiply: inp1=7, inp2=6, start 1 cycle -> done 33 cycles later, prod_hi=0, prod_lo=42.
REQ-028 The bench SHALL cover maximum operands: inp1=inp2=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001.
REQ-029 The bench SHALL cover ignored start and input change (see the list below).
- Stimulus: inp1=3, inp2=5, start once; change inputs to 9 and 9 and pulse start at cycle 10.
- Required response: a single done, with result 15.
REQ-030 The bench SHALL cover reset mid-operation: assert rst_n=0 at RUN cycle 16 -> no done, outputs 0; then inp1=2, inp2=2 -> prod_lo=4.
REQ-031 The bench SHALL cover early exit with SEQ_MULTIPLY_EARLY_EXIT_EN defined (see the list below).
- inp1=100, inp2=1 -> RUN lasts 1 cycle, prod_lo=100.
- inp2=0 -> RUN lasts 1 cycle, product 0.
